// File: rtl/khazad_pkg.sv
// khazad_pkg: shared KHAZAD constants and round-sequencer state encoding
package khazad_pkg;
  localparam int KHAZAD_ROUNDS = 8;
  localparam int KHAZAD_BLOCK_W = 64;
  localparam int KHAZAD_KEY_W = 128;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KEY_EXP   = 3'd1,
    S_DATA_INIT = 3'd2,
    S_ROUND     = 3'd3,
    S_LAST      = 3'd4,
    S_DONE      = 3'd5
  } state_t;
endpackage

// File: rtl/khazad_round_sequencer.sv
// khazad_round_sequencer: per-block control FSM for key expansion, rounds and CBC chaining
module khazad_round_sequencer
  import khazad_pkg::*;
#(
  parameter int NUM_ROUNDS = KHAZAD_ROUNDS,
  parameter int RK_ADDR_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 only_data,
  input  logic                 enc_dec_SEL,
  input  logic                 op_mode,
  input  logic                 first_block,
  output logic                 busy,
  output logic                 key_load,
  output logic                 ks_step,
  output logic                 rk_we,
  output logic [RK_ADDR_W-1:0] rk_waddr,
  output logic [RK_ADDR_W-1:0] rk_raddr,
  output logic                 theta_key,
  output logic                 data_load,
  output logic                 in_xor_en,
  output logic                 out_xor_en,
  output logic                 chain_sel_iv,
  output logic                 round_en,
  output logic                 last_round,
  output logic                 out_we,
  output logic                 chain_we,
  output logic                 finish
);
  localparam int RC_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [RC_W-1:0] RC_N = RC_W'(NUM_ROUNDS);
  localparam logic [RC_W-1:0] RC_PRE_LAST = RC_W'(NUM_ROUNDS - 1);
  state_t r_state, w_next;
  logic [RC_W-1:0] r_rc;
  logic r_key_valid, r_enc, r_cbc, r_first;
  logic w_expand;
  // Decryption walks the round keys backwards.
  function automatic logic [RK_ADDR_W-1:0] rk_map(input logic enc, input logic [RC_W-1:0] rc);
    return enc ? RK_ADDR_W'(rc) : RK_ADDR_W'(NUM_ROUNDS - int'(rc));
  endfunction
  assign w_expand = !only_data || !r_key_valid;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rc <= '0;
      r_key_valid <= 1'b0;
      r_enc <= 1'b0;
      r_cbc <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_enc <= enc_dec_SEL;
          r_cbc <= op_mode;
          r_first <= first_block;
          r_rc <= '0;
        end
        S_KEY_EXP: begin
          r_rc <= (r_rc == RC_N) ? RC_W'(1) : r_rc + 1'b1;
          if (r_rc == RC_N) r_key_valid <= 1'b1;
        end
        S_DATA_INIT: r_rc <= RC_W'(1);
        S_ROUND: r_rc <= r_rc + 1'b1;
        default: ;
      endcase
    end
  end
  always_comb begin
    w_next = r_state;
    key_load = 1'b0;
    ks_step = 1'b0;
    rk_we = 1'b0;
    rk_waddr = '0;
    rk_raddr = '0;
    theta_key = 1'b0;
    data_load = 1'b0;
    in_xor_en = 1'b0;
    out_xor_en = 1'b0;
    chain_sel_iv = 1'b0;
    round_en = 1'b0;
    last_round = 1'b0;
    out_we = 1'b0;
    chain_we = 1'b0;
    finish = 1'b0;
    busy = r_state != S_IDLE;
    case (r_state)
      S_IDLE: if (start) begin
        key_load = w_expand;
        w_next = w_expand ? S_KEY_EXP : S_DATA_INIT;
      end
      S_KEY_EXP: begin
        ks_step = 1'b1;
        rk_we = 1'b1;
        rk_waddr = RK_ADDR_W'(r_rc);
        w_next = (r_rc == RC_N) ? S_DATA_INIT : S_KEY_EXP;
      end
      S_DATA_INIT: begin
        data_load = 1'b1;
        rk_raddr = rk_map(r_enc, '0);
        in_xor_en = r_cbc && r_enc;
        chain_sel_iv = r_first;
        w_next = (NUM_ROUNDS == 1) ? S_LAST : S_ROUND;
      end
      S_ROUND: begin
        round_en = 1'b1;
        rk_raddr = rk_map(r_enc, r_rc);
        theta_key = !r_enc;
        w_next = (r_rc == RC_PRE_LAST) ? S_LAST : S_ROUND;
      end
      S_LAST: begin
        last_round = 1'b1;
        rk_raddr = rk_map(!r_enc, '0);
        w_next = S_DONE;
      end
      S_DONE: begin
        out_we = 1'b1;
        finish = 1'b1;
        out_xor_en = r_cbc && !r_enc;
        chain_sel_iv = r_first;
        chain_we = r_cbc;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_khazad_round_sequencer.sv
// tb_khazad_round_sequencer: randomized and directed check against a per-operation schedule model
module tb_khazad_round_sequencer;
  import khazad_pkg::*;
  localparam int N = 8;
  typedef struct packed {
    logic busy, key_load, ks_step, rk_we;
    logic [3:0] rk_waddr, rk_raddr;
    logic theta_key, data_load, in_xor_en, out_xor_en, chain_sel_iv;
    logic round_en, last_round, out_we, chain_we, finish;
  } exp_t;
  logic clk = 0, RST = 1, start = 0, only_data = 0, enc_dec_SEL = 0, op_mode = 0, first_block = 0;
  logic busy, key_load, ks_step, rk_we, theta_key, data_load, in_xor_en, out_xor_en;
  logic chain_sel_iv, round_en, last_round, out_we, chain_we, finish;
  logic [3:0] rk_waddr, rk_raddr;
  int checks = 0, failures = 0;
  bit kv = 0;
  exp_t sched[$];
  bit skv[$];
  exp_t m_e, d;
  khazad_round_sequencer #(.NUM_ROUNDS(N), .RK_ADDR_W(4)) dut (
    .CLK(clk), .RST(RST), .start(start), .only_data(only_data), .enc_dec_SEL(enc_dec_SEL),
    .op_mode(op_mode), .first_block(first_block), .busy(busy), .key_load(key_load),
    .ks_step(ks_step), .rk_we(rk_we), .rk_waddr(rk_waddr), .rk_raddr(rk_raddr),
    .theta_key(theta_key), .data_load(data_load), .in_xor_en(in_xor_en),
    .out_xor_en(out_xor_en), .chain_sel_iv(chain_sel_iv), .round_en(round_en),
    .last_round(last_round), .out_we(out_we), .chain_we(chain_we), .finish(finish)
  );
  always #5 clk = ~clk;
  assign d = {busy, key_load, ks_step, rk_we, rk_waddr, rk_raddr, theta_key, data_load,
              in_xor_en, out_xor_en, chain_sel_iv, round_en, last_round, out_we, chain_we, finish};
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  function automatic void push(input exp_t e, input bit k);
    sched.push_back(e);
    skv.push_back(k);
  endfunction
  // Whole-operation schedule of expected outputs, one entry per cycle after acceptance.
  function automatic void plan(input bit expand, input bit en, input bit cb, input bit fb);
    exp_t e;
    if (expand)
      for (int i = 0; i <= N; i++) begin
        e = '0; e.busy = 1; e.ks_step = 1; e.rk_we = 1; e.rk_waddr = 4'(i);
        push(e, i == N);
      end
    e = '0; e.busy = 1; e.data_load = 1; e.rk_raddr = en ? 4'd0 : 4'(N);
    e.in_xor_en = cb & en; e.chain_sel_iv = fb;
    push(e, 0);
    for (int r = 1; r < N; r++) begin
      e = '0; e.busy = 1; e.round_en = 1; e.rk_raddr = 4'(en ? r : N - r); e.theta_key = !en;
      push(e, 0);
    end
    e = '0; e.busy = 1; e.last_round = 1; e.rk_raddr = en ? 4'(N) : 4'd0;
    push(e, 0);
    e = '0; e.busy = 1; e.out_we = 1; e.finish = 1; e.out_xor_en = cb & !en;
    e.chain_sel_iv = fb; e.chain_we = cb;
    push(e, 0);
  endfunction
  always @(negedge clk) begin
    m_e = '0;
    if (sched.size() == 0) begin
      m_e.key_load = start && (!only_data || !kv);
      if (start && !RST) plan(!only_data || !kv, enc_dec_SEL, op_mode, first_block);
    end else begin
      m_e = sched.pop_front();
      if (skv.pop_front() && !RST) kv = 1;
    end
    checks++;
    if (d !== m_e) begin
      failures++;
      $display("FAIL outputs t=%0t actual=%h required=%h", $time, d, m_e);
    end
    if (RST) begin
      sched.delete();
      skv.delete();
      kv = 0;
    end
  end
  task automatic op(input bit od, input bit en, input bit cb, input bit fb, input int exp_lat,
                    input int exp_dl, input int p1, input int p2);
    int lat = -1, nf = 0, dl = -1, lr = -1;
    @(posedge clk); #1;
    start = 1; only_data = od; enc_dec_SEL = en; op_mode = cb; first_block = fb;
    for (int c = 0; c <= exp_lat + 12; c++) begin
      @(negedge clk);
      if (finish) begin
        nf++;
        if (lat < 0) lat = c;
      end
      if (data_load) dl = int'(rk_raddr);
      if (last_round) lr = int'(rk_raddr);
      @(posedge clk); #1;
      start = (c + 1 == p1) || (c + 1 == p2);
      {only_data, enc_dec_SEL, op_mode, first_block} = 4'($urandom);
    end
    start = 0;
    check("latency", lat, exp_lat);
    check("finish_count", nf, 1);
    check("data_init_raddr", dl, exp_dl);
    check("last_raddr", lr, en ? N : 0);
  endtask
  initial begin
    int nf;
    @(posedge clk); @(posedge clk); #1;
    RST = 0;
    op(1, 1, 0, 0, 19, 0, -1, -1);
    op(0, 1, 0, 0, 19, 0, -1, -1);
    op(1, 0, 0, 0, 10, 8, -1, -1);
    op(1, 1, 1, 1, 10, 0, -1, -1);
    op(1, 1, 1, 0, 10, 0, -1, -1);
    op(1, 0, 1, 1, 10, 8, -1, -1);
    op(1, 1, 0, 0, 10, 0, 3, 10);
    @(posedge clk); #1;
    start = 1; only_data = 0; enc_dec_SEL = 1; op_mode = 0; first_block = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 RST = 1;
    @(posedge clk); #1;
    RST = 0;
    @(negedge clk);
    check("busy_after_reset", int'(busy), 0);
    nf = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (finish) nf++;
    end
    check("finish_after_reset", nf, 0);
    op(1, 1, 0, 0, 19, 0, -1, -1);
    repeat (400) begin
      @(posedge clk); #1;
      start = $urandom_range(3) == 0;
      {only_data, enc_dec_SEL, op_mode, first_block} = 4'($urandom);
      RST = $urandom_range(63) == 0;
    end
    @(posedge clk); #1;
    RST = 0; start = 0;
    repeat (30) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/khazad_round_sequencer.md
Name: khazad_round_sequencer

Overview:
- FSM that sequences the KHAZAD datapath for each block operation: key expansion into the round-key RAM, initial key addition, full rounds, last round, and the CBC chaining register update.
- Sits between the PS/PL control block (which supplies the start pulse and mode bits) and the cipher datapath.
- Returns the one-cycle finish pulse to the control block.

Parameters:
- NUM_ROUNDS, 8, number of KHAZAD rounds; NUM_ROUNDS+1 round keys are stored.
- RK_ADDR_W, 4, round-key RAM address width; must satisfy 2**RK_ADDR_W >= NUM_ROUNDS+1.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- start  input  1  one-cycle start pulse
- only_data  input  1  1: reuse stored round keys; 0: expand a new key
- enc_dec_SEL  input  1  1: encrypt; 0: decrypt
- op_mode  input  1  1: CBC; 0: ECB
- first_block  input  1  1: chain from IV; 0: chain from previous block
- busy  output  1  high in every non-IDLE state
- key_load  output  1  load the 128-bit key into the key-schedule registers
- ks_step  output  1  advance the key schedule by one round
- rk_we  output  1  round-key RAM write enable
- rk_waddr  output  RK_ADDR_W  round-key write address
- rk_raddr  output  RK_ADDR_W  round-key read address
- theta_key  output  1  apply inverse theta to the read round key (decryption middle rounds)
- data_load  output  1  load the input block into the state register, with initial key addition
- in_xor_en  output  1  XOR the chain value into the input (CBC encrypt)
- out_xor_en  output  1  XOR the chain value into the output (CBC decrypt)
- chain_sel_iv  output  1  1: chain value is the IV register; 0: chain value is the chain register
- round_en  output  1  execute one full round
- last_round  output  1  execute the last round (no theta)
- out_we  output  1  capture the result into the output register
- chain_we  output  1  update the chain register
- finish  output  1  one-cycle completion pulse

Behaviour:
- Reset state: FSM in IDLE, key_valid=0, mode latches=0. All outputs 0, including rk_waddr and rk_raddr.
- Reset in any state, mid-operation included, returns to IDLE next edge. No finish is issued and key_valid is cleared.
- States: IDLE, KEY_EXP, DATA_INIT, ROUND, LAST, DONE. A round counter rc has width $clog2(NUM_ROUNDS+1).
- IDLE:
  - On start, latch enc, cbc, first and rc<=0.
  - If only_data=0 or key_valid=0, go to KEY_EXP and assert key_load in this cycle. Otherwise go to DATA_INIT.
  - only_data=1 with no valid key forces expansion.
- KEY_EXP, NUM_ROUNDS+1 cycles:
  - ks_step=1, rk_we=1, rk_waddr=rc, rc++.
  - At rc==NUM_ROUNDS, set key_valid<=1, rc<=1, go to DATA_INIT.
- DATA_INIT, 1 cycle:
  - data_load=1, rk_raddr = enc ? 0 : NUM_ROUNDS, theta_key=0.
  - in_xor_en = cbc & enc. chain_sel_iv = first.
  - Go to ROUND, or to LAST if NUM_ROUNDS==1.
- ROUND, rc=1..NUM_ROUNDS-1:
  - round_en=1, rk_raddr = enc ? rc : NUM_ROUNDS-rc, theta_key = !enc, rc++.
  - At rc==NUM_ROUNDS-1, go to LAST.
- LAST, 1 cycle:
  - last_round=1, rk_raddr = enc ? NUM_ROUNDS : 0, theta_key=0. Go to DONE.
- DONE, 1 cycle:
  - out_we=1, finish=1.
  - out_xor_en = cbc & !enc, chain_sel_iv = first.
  - chain_we = cbc. The datapath captures ciphertext: the output when encrypting, the input when decrypting.
  - Go to IDLE.
- Latency, with start seen at edge 0 in IDLE:
  - With key expansion, finish is high in cycle 2*NUM_ROUNDS+3 (19 at the default).
  - Without key expansion, finish is high in cycle NUM_ROUNDS+2 (10 at the default).
- start while busy, DONE included, is ignored. The mode inputs are sampled only on an accepted start.
- All outputs are combinational decodes of state, rc and the latched mode bits. No output depends on the live mode inputs after acceptance.
- The ECB/CBC and enc/dec selects are fixed for the whole operation, even if the PS changes them mid-operation.

Decomposition:
- Shared package khazad_pkg holds:
  - KHAZAD_ROUNDS=8, KHAZAD_BLOCK_W=64, KHAZAD_KEY_W=128
  - state encoding constants (localparam, 3-bit)
- A single module, no sub-module. rc and the FSM are small enough to live together.
- The address mapping (enc ? rc : NUM_ROUNDS-rc) is an inline function.

Test Plan:
- ECB encrypt, new key: start with only_data=0, enc=1, op_mode=0 -> key_load at cycle 0; rk_we on cycles 1..9 with rk_waddr 0..8; data_load at cycle 10; rk_raddr 1..7 on cycles 11..17; last_round with rk_raddr=8 at cycle 18; finish at cycle 19; key_valid=1 afterwards.
- ECB decrypt, key reuse: only_data=1 after the first test -> no KEY_EXP; data_load at cycle 1 with rk_raddr=8; rk_raddr 7..1 with theta_key=1; last_round with rk_raddr=0 and theta_key=0; finish at cycle 10.
- CBC encrypt chain: first_block=1 then 0 -> in_xor_en=1 at DATA_INIT with chain_sel_iv 1 then 0; chain_we=1 and out_xor_en=0 at DONE.
- CBC decrypt: op_mode=1, enc=0 -> in_xor_en=0; out_xor_en=1 and chain_we=1 in the finish cycle.
- only_data=1 straight after reset -> forced KEY_EXP; finish at cycle 19.
- Reset at cycle 5 of KEY_EXP -> IDLE next edge; no finish; busy=0; next start with only_data=1 still expands the key.
- Start pulses at cycles 3 and 10 (the DONE cycle) while busy -> ignored; exactly one finish.
